// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the addsub arbiter slice.
// Operation select encoding and tag-width helper.
package addsub_arbiter_pkg;

    localparam logic SEL_ADD = 1'b1;
    localparam logic SEL_SUB = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between requesters and the shared adder.
// master = requester/consumer side, slave = arbiter side.
interface addsub_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_sel;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/addsub.sv
// Shared two's-complement adder-subtractor, wraps modulo 2^WIDTH.
// sel = SEL_ADD gives a+b, otherwise a-b.
module addsub
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    // purely combinational result
    always_comb begin
        y = (sel == SEL_ADD) ? (a + b) : (a - b);
    end
endmodule

// File: rtl/addsub_arbiter_rr_arbiter.sv
// Round-robin priority search starting at ptr.
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    int j;

    // first requester at or above ptr, wrapping modulo N_REQ
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = (int'(ptr) + k) % N_REQ;
                if (!any && req[j]) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    idx      = ID_W'(j);
                end
            end
        end
    end
endmodule

// File: rtl/addsub_arbiter.sv
// Two-stage pipeline sharing one addsub among N_REQ requesters.
// S1 holds granted operands, S2 holds the tagged result.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_arbiter_if.slave    bus,
    output logic               busy
);
    logic             v1, v2;
    logic [WIDTH-1:0] a1, b1;
    logic             sel1;
    logic [ID_W-1:0]  id1;
    logic [ID_W-1:0]  ptr;
    logic [WIDTH-1:0] data2;
    logic [ID_W-1:0]  id2;
    logic [WIDTH-1:0] res;
    logic             adv1, adv2, accept;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gidx;
    logic             gany;
    logic [WIDTH-1:0] a_in, b_in;

    // stall chain: S2 frees first, S1 follows, new accept last
    always_comb begin
        adv2   = !v2 || bus.rsp_ready;
        adv1   = v1 && adv2;
        accept = !v1 || adv1;
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .en    (accept && rst_n),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // operands of the granted requester
    always_comb begin
        a_in = bus.req_a[int'(gidx)*WIDTH +: WIDTH];
        b_in = bus.req_b[int'(gidx)*WIDTH +: WIDTH];
    end

    addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (a1),
        .b   (b1),
        .sel (sel1),
        .y   (res)
    );

    // S1 operand register and rotation pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            sel1 <= 1'b0;
            id1  <= '0;
            ptr  <= '0;
        end else if (accept) begin
            v1 <= gany;
            if (gany) begin
                a1   <= a_in;
                b1   <= b_in;
                sel1 <= bus.req_sel[gidx];
                id1  <= gidx;
                ptr  <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);
            end
        end
    end

    // S2 result register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            data2 <= '0;
            id2   <= '0;
        end else if (adv1) begin
            v2    <= 1'b1;
            data2 <= res;
            id2   <= id1;
        end else if (v2 && bus.rsp_ready) begin
            v2 <= 1'b0;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = v2;
    assign bus.rsp_data  = data2;
    assign bus.rsp_id    = id2;
    assign busy          = v1 | v2;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: vector table plus
// hand-written rotation, backpressure, fairness and reset sequences.
module tb_addsub_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;

    addsub_arbiter_if #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) bus ();

    addsub_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[5];
    logic [31:0] ra[4];
    logic [31:0] rb[4];
    logic        rs[4];
    logic [31:0] rexp[4];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = ra[i];
            bus.req_b[i*W +: W] = rb[i];
            bus.req_sel[i]      = rs[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;

        vt[0] = '{2, 32'd7, 32'd3, 1'b0, 32'd4};
        vt[1] = '{1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0};
        vt[2] = '{0, 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF};
        vt[3] = '{3, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789};
        vt[4] = '{0, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF};

        ra = '{32'd100, 32'd200, 32'd300, 32'd400};
        rb = '{32'd1, 32'd50, 32'd700, 32'd400};
        rs = '{1'b1, 1'b0, 1'b1, 1'b0};
        rexp = '{32'd101, 32'd150, 32'd1000, 32'd0};

        // reset state
        #1;
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        do_reset();

        // all requesters valid: strict rotation from ptr 0
        load_ops();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8)
                chk("rr_grant", 64'(bus.req_ready), 64'(4'b1 << (c % 4)));
            if (c >= 2) begin
                chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
                chk("rr_id", 64'(bus.rsp_id), 64'((c - 2) % 4));
                chk("rr_data", 64'(bus.rsp_data), 64'(rexp[(c - 2) % 4]));
            end
        end
        @(negedge clk);
        #1;
        chk("rr_drained", 64'(bus.rsp_valid), 64'd0);

        // table: single requester, granted regardless of ptr
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            bus.req_a[vt[v].id*W +: W] = vt[v].a;
            bus.req_b[vt[v].id*W +: W] = vt[v].b;
            bus.req_sel[vt[v].id]      = vt[v].sel;
            bus.req_valid = 4'b1 << vt[v].id;
            #1;
            chk("vec_grant", 64'(bus.req_ready), 64'(4'b1 << vt[v].id));
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            chk("vec_early", 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
            #1;
            chk("vec_valid", 64'(bus.rsp_valid), 64'd1);
            chk("vec_data", 64'(bus.rsp_data), 64'(vt[v].exp));
            chk("vec_id", 64'(bus.rsp_id), 64'(vt[v].id));
            @(negedge clk);
            #1;
            chk("vec_idle", 64'(busy), 64'd0);
        end

        // backpressure: five stalled cycles then in-order drain
        do_reset();
        ra = '{32'd10, 32'd20, 32'd5, 32'd0};
        rb = '{32'd1, 32'd5, 32'd9, 32'd0};
        rs = '{1'b1, 1'b0, 1'b0, 1'b0};
        load_ops();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        #1;
        chk("bp_g0", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        #1;
        chk("bp_g1", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        for (int c = 2; c < 5; c++) begin
            #1;
            chk("bp_full", 64'(bus.req_ready), 64'd0);
            chk("bp_hold_v", 64'(bus.rsp_valid), 64'd1);
            chk("bp_hold_d", 64'(bus.rsp_data), 64'd11);
            chk("bp_hold_id", 64'(bus.rsp_id), 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_g2", 64'(bus.req_ready), 64'b0100);
        chk("bp_r0", 64'(bus.rsp_data), 64'd11);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("bp_r1_v", 64'(bus.rsp_valid), 64'd1);
        chk("bp_r1_id", 64'(bus.rsp_id), 64'd1);
        chk("bp_r1_d", 64'(bus.rsp_data), 64'd15);
        @(negedge clk);
        #1;
        chk("bp_r2_v", 64'(bus.rsp_valid), 64'd1);
        chk("bp_r2_id", 64'(bus.rsp_id), 64'd2);
        chk("bp_r2_d", 64'(bus.rsp_data), 64'hFFFF_FFFC);
        @(negedge clk);
        #1;
        chk("bp_empty", 64'(bus.rsp_valid), 64'd0);
        chk("bp_busy", 64'(busy), 64'd0);

        // fairness: move ptr to 2, then only 1 and 3 valid
        do_reset();
        bus.req_valid = 4'b0010;
        #1;
        chk("fair_setup", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid = 4'b1010;
        #1;
        chk("fair_g3", 64'(bus.req_ready), 64'b1000);
        @(negedge clk);
        #1;
        chk("fair_g1", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        #1;
        chk("fair_g3b", 64'(bus.req_ready), 64'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        // reset with both stages full
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        chk("mr_full_busy", 64'(busy), 64'd1);
        chk("mr_full_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_data", 64'(bus.rsp_data), 64'd0);
        chk("mr_id", 64'(bus.rsp_id), 64'd0);
        chk("mr_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mr_no_stale", 64'(bus.rsp_valid), 64'd0);
        end
        bus.req_valid = 4'hF;
        #1;
        chk("mr_ptr0", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
